// File: rtl/cbus_arb_pkg.sv
// Shared types for the cache-bus arbiter: cbus channel structs, FSM state enum and index helpers.
package cbus_arb_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 64;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [3:0]             len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Width of a master index; NUM_MASTERS is at least 2, so this is never zero.
  function automatic int unsigned arb_idx_w(input int unsigned num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: first valid index at or after the pointer, wrapping around.
module rr_picker
  import cbus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IdxW = arb_idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_valid,
  input  logic [IdxW-1:0]        i_ptr,
  output logic [IdxW-1:0]        o_idx,
  output logic                   o_any
);

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_MASTERS) begin
      sum = sum - NUM_MASTERS;
    end
    return IdxW'(sum);
  endfunction

  always_comb begin
    logic [IdxW-1:0] cand;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = wrap_add(i_ptr, k);
      if (!o_any && i_valid[cand]) begin
        o_any = 1'b1;
        o_idx = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Grants whole cbus transactions (up to iresp.last) to one master at a time.
// Define CBUS_ARBITER_RR_EN for round-robin; otherwise the lowest requesting index wins.
module cbus_arbiter
  import cbus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t oresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t iresp
);

  localparam int unsigned IdxW = arb_idx_w(NUM_MASTERS);
  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(NUM_MASTERS - 1);

  arb_state_e              r_state, w_state_next;
  idx_t                    r_sel, w_sel_next;
  idx_t                    w_ptr, w_win;
  logic                    w_any;
  logic                    w_done;
  logic [NUM_MASTERS-1:0]  w_valid;

  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_valid[i] = ireqs[i].valid;
    end
  end

  // Completion is decided by the memory side alone; beats are never counted.
  assign w_done = (r_state == ARB_BUSY) && iresp.ready && iresp.last;

`ifdef CBUS_ARBITER_RR_EN
  idx_t r_ptr, w_ptr_next;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_done) begin
      w_ptr_next = (r_sel == LastIdx) ? '0 : r_sel + idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .i_valid(w_valid),
    .i_ptr  (w_ptr),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    oreq         = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      oresps[j] = '0;
    end
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_next = ARB_BUSY;
          w_sel_next   = w_win;
        end
      end
      ARB_BUSY: begin
        oreq          = ireqs[r_sel];
        oresps[r_sel] = iresp;
        if (w_done) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter; expectations follow CBUS_ARBITER_RR_EN.
module tb_cbus_arbiter;
  import cbus_arb_pkg::*;

  localparam int unsigned N = 2;
`ifdef CBUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t oresps [N];
  cbus_req_t  oreq;
  cbus_resp_t iresp;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(
    .NUM_MASTERS(N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .oresps(oresps),
    .oreq  (oreq),
    .iresp (iresp)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    iresp = '0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    clear_inputs();
    cyc();
    reset = 1'b0;
  endtask

  function automatic cbus_req_t mk_rd(input logic [31:0] a, input logic [3:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.size     = 3'd3;
    r.addr     = a;
    r.len      = len;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [63:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ireqs[0] = mk_rd(32'h0000_0100, 4'd0);
    cyc();
    cyc();
    smp();
    n_cmp++;
    if (oreq !== '0) begin
      n_fail++; $display("FAIL reset_oreq: got %h want 0", oreq);
    end
    n_cmp++;
    if (oresps[0] !== '0 || oresps[1] !== '0) begin
      n_fail++; $display("FAIL reset_oresps: got %h/%h want 0/0", oresps[0], oresps[1]);
    end
    cyc();
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      cyc();
      smp();
      n_cmp++;
      if (oreq.valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_valid c%0d: got %b want 0", c, oreq.valid);
      end
      n_cmp++;
      if (oresps[0] !== '0 || oresps[1] !== '0) begin
        n_fail++; $display("FAIL idle_resps c%0d: got %h/%h want 0", c, oresps[0], oresps[1]);
      end
    end
  endtask

  task automatic test_single_read();
    cbus_req_t  req0;
    cbus_resp_t exp;
    int         beats;
    int         last_at;
    req0    = mk_rd(32'h0000_1000, 4'd3);
    beats   = 0;
    last_at = -1;
    cyc();
    ireqs[0] = req0;
    smp();
    n_cmp++;
    if (oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL sr_bubble: got %b want 0", oreq.valid);
    end
    for (int b = 0; b < 4; b++) begin
      cyc();
      exp   = mk_resp(1'b1, (b == 3), 64'hA0 + 64'(b));
      iresp = exp;
      smp();
      n_cmp++;
      if (oreq !== req0) begin
        n_fail++; $display("FAIL sr_oreq b%0d: got %h want %h", b, oreq, req0);
      end
      n_cmp++;
      if (oresps[0] !== exp) begin
        n_fail++; $display("FAIL sr_resp0 b%0d: got %h want %h", b, oresps[0], exp);
      end
      n_cmp++;
      if (oresps[1] !== '0) begin
        n_fail++; $display("FAIL sr_resp1 b%0d: got %h want 0", b, oresps[1]);
      end
      if (oresps[0].ready) beats++;
      if (oresps[0].last) last_at = b;
    end
    cyc();
    clear_inputs();
    smp();
    n_cmp++;
    if (oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL sr_done_idle: got %b want 0", oreq.valid);
    end
    n_cmp++;
    if (beats != 4 || last_at != 3) begin
      n_fail++; $display("FAIL sr_beats: got %0d beats last at %0d want 4 at 3", beats, last_at);
    end
  endtask

  task automatic test_simultaneous();
    cbus_req_t  r0, r1;
    cbus_resp_t exp;
    do_reset();
    r0 = mk_rd(32'h0000_2000, 4'd0);
    r1 = mk_rd(32'h0000_3000, 4'd0);
    cyc();
    ireqs[0] = r0;
    ireqs[1] = r1;
    smp();
    cyc();
    exp   = mk_resp(1'b1, 1'b1, 64'hB0);
    iresp = exp;
    smp();
    n_cmp++;
    if (oreq !== r0) begin
      n_fail++; $display("FAIL sim_first: got %h want %h", oreq, r0);
    end
    n_cmp++;
    if (oresps[0] !== exp || oresps[1] !== '0) begin
      n_fail++; $display("FAIL sim_first_resp: got %h/%h want %h/0", oresps[0], oresps[1], exp);
    end
    cyc();
    ireqs[0] = '0;
    iresp    = '0;
    smp();
    n_cmp++;
    if (oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL sim_bubble: got %b want 0", oreq.valid);
    end
    cyc();
    exp   = mk_resp(1'b1, 1'b1, 64'hB1);
    iresp = exp;
    smp();
    n_cmp++;
    if (oreq !== r1) begin
      n_fail++; $display("FAIL sim_second: got %h want %h", oreq, r1);
    end
    n_cmp++;
    if (oresps[1] !== exp || oresps[0] !== '0) begin
      n_fail++; $display("FAIL sim_second_resp: got %h/%h want 0/%h", oresps[0], oresps[1], exp);
    end
    cyc();
    clear_inputs();
  endtask

  // Master 0 alone moves the pointer to 1, so a following tie goes to master 1 under RR.
  task automatic test_rr_repeat();
    cbus_req_t r0, a0, a1, first, second;
    r0 = mk_rd(32'h0000_2100, 4'd0);
    a0 = mk_rd(32'h0000_2200, 4'd0);
    a1 = mk_rd(32'h0000_3200, 4'd0);
    cyc();
    ireqs[0] = r0;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hC0);
    smp();
    n_cmp++;
    if (oreq !== r0) begin
      n_fail++; $display("FAIL rep_solo: got %h want %h", oreq, r0);
    end
    cyc();
    clear_inputs();
    cyc();
    ireqs[0] = a0;
    ireqs[1] = a1;
    first  = RR ? a1 : a0;
    second = RR ? a0 : a1;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hC1);
    smp();
    n_cmp++;
    if (oreq !== first) begin
      n_fail++; $display("FAIL rep_first: got %h want %h", oreq, first);
    end
    cyc();
    if (RR) ireqs[1] = '0;
    else ireqs[0] = '0;
    iresp = '0;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hC2);
    smp();
    n_cmp++;
    if (oreq !== second) begin
      n_fail++; $display("FAIL rep_second: got %h want %h", oreq, second);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_write_wait();
    cbus_req_t  w1;
    cbus_resp_t exp;
    w1          = '0;
    w1.valid    = 1'b1;
    w1.is_write = 1'b1;
    w1.size     = 3'd3;
    w1.addr     = 32'h0000_4000;
    w1.strobe   = 8'h0F;
    w1.data     = 64'hDEAD_BEEF_0123_4567;
    w1.len      = 4'd1;
    cyc();
    ireqs[1] = w1;
    smp();
    n_cmp++;
    if (oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL ww_bubble: got %b want 0", oreq.valid);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      exp   = (k < 3) ? '0 : mk_resp(1'b1, (k == 4), 64'h0);
      iresp = exp;
      smp();
      n_cmp++;
      if (oreq !== w1) begin
        n_fail++; $display("FAIL ww_oreq k%0d: got %h want %h", k, oreq, w1);
      end
      n_cmp++;
      if (oresps[1] !== exp || oresps[0] !== '0) begin
        n_fail++; $display("FAIL ww_resp k%0d: got %h/%h want 0/%h", k, oresps[0], oresps[1], exp);
      end
    end
    cyc();
    clear_inputs();
    smp();
    n_cmp++;
    if (oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL ww_done: got %b want 0", oreq.valid);
    end
  endtask

  task automatic test_starve();
    cbus_req_t  a0, a1, exp_req;
    cbus_resp_t last_rsp;
    bit         m1_served;
    do_reset();
    a0        = mk_rd(32'h0000_5000, 4'd0);
    a1        = mk_rd(32'h0000_6000, 4'd0);
    last_rsp  = mk_resp(1'b1, 1'b1, 64'hD0);
    m1_served = 1'b0;
    cyc();
    ireqs[0] = a0;
    cyc();
    ireqs[1] = a1;
    iresp    = last_rsp;
    smp();
    n_cmp++;
    if (oreq !== a0) begin
      n_fail++; $display("FAIL st_g0: got %h want %h", oreq, a0);
    end
    for (int g = 1; g <= 3; g++) begin
      cyc();
      iresp = '0;
      if (m1_served) ireqs[1] = '0;
      smp();
      n_cmp++;
      if (oreq.valid !== 1'b0) begin
        n_fail++; $display("FAIL st_bubble g%0d: got %b want 0", g, oreq.valid);
      end
      cyc();
      iresp   = last_rsp;
      exp_req = (RR && g == 1) ? a1 : a0;
      smp();
      n_cmp++;
      if (oreq !== exp_req) begin
        n_fail++; $display("FAIL st_grant g%0d: got %h want %h", g, oreq, exp_req);
      end
      n_cmp++;
      if (oresps[1] !== ((exp_req == a1) ? last_rsp : '0)) begin
        n_fail++; $display("FAIL st_resp1 g%0d: got %h", g, oresps[1]);
      end
      m1_served = (exp_req == a1);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    cbus_req_t r0, r4, b0, b1;
    do_reset();
    r0 = mk_rd(32'h0000_7000, 4'd0);
    r4 = mk_rd(32'h0000_7100, 4'd3);
    b0 = mk_rd(32'h0000_7200, 4'd0);
    b1 = mk_rd(32'h0000_7300, 4'd0);
    cyc();
    ireqs[0] = r0;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hE0);
    cyc();
    ireqs[0] = r4;
    iresp    = '0;
    cyc();
    iresp = mk_resp(1'b1, 1'b0, 64'hE1);
    smp();
    n_cmp++;
    if (oreq !== r4) begin
      n_fail++; $display("FAIL rm_beat1: got %h want %h", oreq, r4);
    end
    cyc();
    iresp = mk_resp(1'b1, 1'b0, 64'hE2);
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    ireqs[0] = '0;
    iresp    = mk_resp(1'b1, 1'b0, 64'hE3);
    smp();
    n_cmp++;
    if (oreq !== '0) begin
      n_fail++; $display("FAIL rm_oreq: got %h want 0", oreq);
    end
    n_cmp++;
    if (oresps[0] !== '0 || oresps[1] !== '0) begin
      n_fail++; $display("FAIL rm_resps: got %h/%h want 0/0", oresps[0], oresps[1]);
    end
    cyc();
    iresp    = '0;
    ireqs[0] = b0;
    ireqs[1] = b1;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hE4);
    smp();
    n_cmp++;
    if (oreq !== b0) begin
      n_fail++; $display("FAIL rm_ptr: got %h want %h", oreq, b0);
    end
    cyc();
    ireqs[0] = '0;
    iresp    = '0;
    cyc();
    iresp = mk_resp(1'b1, 1'b1, 64'hE5);
    smp();
    n_cmp++;
    if (oreq !== b1) begin
      n_fail++; $display("FAIL rm_after: got %h want %h", oreq, b1);
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_read();
    test_simultaneous();
    test_rr_repeat();
    test_write_wait();
    test_starve();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
